// File: rtl/lcd_scanout.sv
// Framebuffer scan-out: after each render-complete pulse, reads the LCD framebuffer
// in raster order and streams palette-mapped 8-bit grayscale pixels over valid/ready.
module lcd_scanout #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              render_complete,
  input  logic [7:0]        palette,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [1:0]        fb_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, READ, LATCH, SEND} state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          pal_q, pal_d;
  logic [7:0]          data_q, data_d;
  logic                sof_q, sof_d;
  logic                eol_q, eol_d;
  logic                valid_q, valid_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic [1:0]          shade;

  function automatic logic [7:0] shade_to_gray(input logic [1:0] s);
    case (s)
      2'd0:    return 8'd255;
      2'd1:    return 8'd170;
      2'd2:    return 8'd85;
      default: return 8'd0;
    endcase
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    pal_d     = pal_q;
    data_d    = data_q;
    sof_d     = sof_q;
    eol_d     = eol_q;
    valid_d   = 1'b0;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    shade     = pal_q[{fb_rd_data, 1'b0} +: 2];

    unique case (state_q)
      IDLE: begin
        if (render_complete) begin
          pal_d   = palette;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: state_d = LATCH;
      LATCH: begin
        data_d  = shade_to_gray(shade);
        sof_d   = (x_q == '0) && (y_q == '0);
        eol_d   = (x_q == X_LAST);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (pix_ready) begin
          if (x_q != X_LAST) begin
            x_d     = x_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            rd_en_d = 1'b1;
            state_d = READ;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            rd_en_d = 1'b1;
            state_d = READ;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame request is only honoured from IDLE; anything else is an overrun.
    if (render_complete && (state_q != IDLE)) overrun_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      pal_q     <= '0;
      data_q    <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      valid_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      pal_q     <= pal_d;
      data_q    <= data_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      valid_q   <= valid_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign fb_rd_en   = rd_en_q;
  assign fb_addr    = addr_q;
  assign pix_valid  = valid_q;
  assign pix_data   = data_q;
  assign pix_sof    = sof_q;
  assign pix_eol    = eol_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Reads the 160x144 rendered LCD framebuffer after each render-complete pulse from whizgraphics.
- Streams the frame out pixel by pixel as 8-bit grayscale over a valid/ready interface, with start-of-frame and end-of-line markers.
- Feeds the frame-capture/PGM writer in benches and an external display bridge on hardware.

Parameters:
- WIDTH, 160, pixels per line.
- HEIGHT, 144, lines per frame.
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- render_complete  in  1  one-cycle pulse: frame in framebuffer is final.
- palette  in  8  BGP-format palette; 2-bit shade for colour index i is palette[2i+1:2i].
- fb_rd_en  out  1  framebuffer read strobe.
- fb_addr  out  ADDR_W  read address, equal to y*WIDTH+x.
- fb_rd_data  in  2  colour index, valid exactly 1 cycle after fb_rd_en.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts pixel.
- pix_data  out  8  grayscale value.
- pix_sof  out  1  qualifies pixel (0,0).
- pix_eol  out  1  qualifies the last pixel of each line (x=WIDTH-1).
- busy  out  1  frame scan in progress.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.
- overrun  out  1  sticky: render_complete arrived while busy.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, x=y=0, fb_addr=0, fb_rd_en=0, pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, busy=0, frame_done=0, overrun=0, captured palette=0.
- FSM states: IDLE, READ, LATCH, SEND.
- IDLE: on render_complete, capture palette into pal_q; x=y=0; go to READ; busy=1 from the next cycle. The palette is frozen for the whole frame.
- READ: assert fb_rd_en for exactly 1 cycle with fb_addr=y*WIDTH+x; go to LATCH.
- LATCH: sample fb_rd_data.
  - shade = pal_q[2*idx+1:2*idx].
  - Gray mapping: shade 0 -> 255, 1 -> 170, 2 -> 85, 3 -> 0.
  - Register pix_data, pix_sof=(x==0 && y==0), pix_eol=(x==WIDTH-1); go to SEND.
- SEND: pix_valid=1.
  - pix_data, pix_sof and pix_eol hold stable until the transfer cycle (pix_valid && pix_ready).
  - pix_valid never deasserts before the transfer.
  - On transfer with x<WIDTH-1: x++ and go to READ.
  - On transfer with x==WIDTH-1 and y<HEIGHT-1: x=0, y++ and go to READ.
  - On transfer with x==WIDTH-1 and y==HEIGHT-1: go to IDLE, pulse frame_done for 1 cycle, busy=0 in that same cycle.
- fb_addr is maintained incrementally (+1 per pixel, no multiplier) and never exceeds WIDTH*HEIGHT-1.
- Minimum 3 cycles per pixel when pix_ready is held high; one frame is 69120 cycles minimum with default parameters.
- render_complete while busy: ignored (scan continues unchanged); overrun set to 1 and held until reset.
- render_complete in the same cycle that frame_done pulses: the FSM is in IDLE that cycle, so a new frame starts; overrun is not set.
- pix_ready is ignored outside SEND.
- Reset asserted mid-frame: immediate return to reset values; no partial frame resumes after reset release.
- Outputs are registered; no combinational path from pix_ready to pix_valid.

Test Plan:
- Reset check: hold reset=0 for 3 cycles -> all outputs 0. Release reset with no render_complete -> busy stays 0 and fb_rd_en never asserts for 100 cycles.
- Flat frame: framebuffer all index 0, palette=8'hE4, pix_ready=1, one render_complete pulse.
  - Exactly 23040 transfers, all pix_data=255.
  - pix_sof high on transfer 1 only; pix_eol on every 160th transfer (144 total).
  - frame_done pulses once, 69120 cycles after the first READ.
- Palette mapping: fb index at addr i = i%4, palette=8'hE4 -> pix_data sequence 255,170,85,0 repeating. Palette=8'h1B -> 0,85,170,255. Change palette mid-frame -> output unchanged.
- Backpressure: pix_ready pseudo-random at 30% duty.
  - pix_data/pix_sof/pix_eol stable while pix_valid && !pix_ready.
  - Pixel order matches addresses 0..23039; fb_rd_en asserts exactly once per pixel.
- Overrun: second render_complete at pixel 500 -> scan completes normally, overrun=1 and stays 1, only one frame_done. render_complete in the frame_done cycle -> new frame starts, overrun stays 0.
- Reset mid-frame: assert reset at pixel 1000 -> outputs reset that cycle. A new render_complete after release -> first transfer carries pix_sof=1, fb_addr restarts at 0.
